// File: rtl/fp16_mul_sequencer_if.sv
// Request/response bundle between the FP16 multiply sequencer, its requester
// and the external significand multiplier core.
interface fp16_mul_sequencer_if #(
    parameter int BIT_WIDTH = 10
);
    logic                 start;
    logic [15:0]          op_a;
    logic [15:0]          op_b;
    logic                 ready;
    logic                 sig_start;
    logic [BIT_WIDTH-1:0] sig_input_a;
    logic [BIT_WIDTH-1:0] sig_input_b;
    logic                 sig_hidden_a;
    logic                 sig_hidden_b;
    logic                 sig_sign;
    logic [BIT_WIDTH-1:0] sig_result;
    logic                 sig_valid;
    logic                 sig_msb;
    logic [15:0]          result;
    logic                 result_valid;
    logic                 timeout_err;

    modport master (
        output start, op_a, op_b, sig_result, sig_valid, sig_msb,
        input  ready, sig_start, sig_input_a, sig_input_b, sig_hidden_a,
               sig_hidden_b, sig_sign, result, result_valid, timeout_err
    );

    modport slave (
        input  start, op_a, op_b, sig_result, sig_valid, sig_msb,
        output ready, sig_start, sig_input_a, sig_input_b, sig_hidden_a,
               sig_hidden_b, sig_sign, result, result_valid, timeout_err
    );
endinterface

// File: rtl/fp16_mul_sequencer.sv
// FP16 multiply sequencer: classifies operands, resolves special cases locally
// and otherwise drives an external significand core, then packs the result.
module fp16_mul_sequencer #(
    parameter int BIT_WIDTH = 10,
    parameter int EXP_WIDTH = 5,
    parameter int EXP_BIAS  = 15,
    parameter int TIMEOUT   = 31
) (
    input  logic                  clk,
    input  logic                  reset,
    fp16_mul_sequencer_if.slave   bus
);
    localparam int SB = BIT_WIDTH + EXP_WIDTH;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [15:0] QNAN    = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(BIT_WIDTH-1){1'b0}}};
    localparam logic [14:0] INF_MAG = {{EXP_WIDTH{1'b1}}, {BIT_WIDTH{1'b0}}};

    typedef enum logic [1:0] {IDLE, CAPTURE, WAIT, DONE} state_t;

    state_t                 state, nxt;
    logic [15:0]            a_q, b_q, result_q;
    logic [CW-1:0]          cnt;
    logic                   err_q;

    logic [EXP_WIDTH-1:0]   ea, eb;
    logic [BIT_WIDTH-1:0]   ma, mb;
    logic                   sign, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, special;
    logic [15:0]            special_val, packed_val;
    logic signed [EXP_WIDTH+1:0] e_sum;
    logic                   ovf, unf, cnt_hit;

    assign ea      = a_q[BIT_WIDTH +: EXP_WIDTH];
    assign eb      = b_q[BIT_WIDTH +: EXP_WIDTH];
    assign ma      = a_q[BIT_WIDTH-1:0];
    assign mb      = b_q[BIT_WIDTH-1:0];
    assign sign    = a_q[SB] ^ b_q[SB];
    assign a_zero  = (ea == '0);
    assign b_zero  = (eb == '0);
    assign a_inf   = (ea == '1) && (ma == '0);
    assign b_inf   = (eb == '1) && (mb == '0);
    assign a_nan   = (ea == '1) && (ma != '0);
    assign b_nan   = (eb == '1) && (mb != '0);
    assign special = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;
    assign cnt_hit = (cnt == TIMEOUT[CW-1:0]);

    // NaN dominates, then the invalid Inf*0, then Inf, then signed zero.
    always_comb begin
        special_val = {sign, 15'h0000};
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            special_val = QNAN;
        else if (a_inf || b_inf)
            special_val = {sign, INF_MAG};
    end

    // Signed headroom so both overflow past the max exponent and underflow below 1 are visible.
    always_comb begin
        e_sum = $signed({2'b00, ea}) + $signed({2'b00, eb})
              - $signed(EXP_BIAS[EXP_WIDTH+1:0])
              + $signed({{(EXP_WIDTH+1){1'b0}}, bus.sig_msb});
        ovf   = !e_sum[EXP_WIDTH+1] && (e_sum[EXP_WIDTH] || (&e_sum[EXP_WIDTH-1:0]));
        unf   = e_sum[EXP_WIDTH+1] || (e_sum == '0);
        if (ovf)      packed_val = {sign, INF_MAG};
        else if (unf) packed_val = {sign, 15'h0000};
        else          packed_val = {sign, e_sum[EXP_WIDTH-1:0], bus.sig_result};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (bus.start) nxt = CAPTURE;
            CAPTURE: nxt = special ? DONE : WAIT;
            WAIT:    if (bus.sig_valid || cnt_hit) nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.ready        = (state == IDLE);
        bus.sig_start    = (state == CAPTURE) && !special;
        bus.result_valid = (state == DONE);
        bus.timeout_err  = (state == DONE) && err_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            cnt      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    a_q <= bus.op_a;
                    b_q <= bus.op_b;
                end
                CAPTURE: begin
                    cnt <= '0;
                    if (special) begin
                        result_q <= special_val;
                        err_q    <= 1'b0;
                    end
                end
                // A strobe on the final counted cycle still beats the abort.
                WAIT: if (bus.sig_valid) begin
                    result_q <= packed_val;
                    err_q    <= 1'b0;
                end else if (cnt_hit) begin
                    result_q <= QNAN;
                    err_q    <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.sig_input_a  = ma;
    assign bus.sig_input_b  = mb;
    assign bus.sig_hidden_a = |ea;
    assign bus.sig_hidden_b = |eb;
    assign bus.sig_sign     = sign;
    assign bus.result       = result_q;
endmodule

// File: tb/tb_fp16_mul_sequencer.sv
// Randomized and directed bench for fp16_mul_sequencer with a stub significand core.
module tb_fp16_mul_sequencer;
    localparam int TIMEOUT = 31;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    fp16_mul_sequencer_if #(.BIT_WIDTH(10)) bus ();

    fp16_mul_sequencer #(
        .BIT_WIDTH(10), .EXP_WIDTH(5), .EXP_BIAS(15), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // Reference product from the arithmetic rules; core result/msb are given.
    function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                            input logic [9:0] r, input logic m,
                                            output bit special);
        int ea, eb, e;
        bit s, az, bz, ai, bi, an, bn;
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        s  = a[15] ^ b[15];
        az = (ea == 0);
        bz = (eb == 0);
        ai = (ea == 31) && (a[9:0] == 0);
        bi = (eb == 31) && (b[9:0] == 0);
        an = (ea == 31) && (a[9:0] != 0);
        bn = (eb == 31) && (b[9:0] != 0);
        special = 1'b1;
        if (an || bn || (ai && bz) || (bi && az)) return 16'h7E00;
        if (ai || bi) return {s, 15'h7C00};
        if (az || bz) return {s, 15'h0000};
        special = 1'b0;
        e = ea + eb - 15 + int'(m);
        if (e >= 31) return {s, 15'h7C00};
        if (e <= 0)  return {s, 15'h0000};
        return {s, e[4:0], r};
    endfunction

    function automatic logic [15:0] rand_op();
        logic [31:0] rnd;
        logic [4:0]  e;
        int          sel;
        rnd = $urandom;
        sel = $urandom_range(0, 9);
        if (sel == 0)      e = 5'd0;
        else if (sel <= 2) e = 5'd31;
        else               e = 5'($urandom_range(1, 30));
        if (sel == 1) return {rnd[15], e, 10'h000};
        return {rnd[15], e, rnd[9:0]};
    endfunction

    // Drives one transaction; start is in cycle 1, lat is the cycle index of result_valid.
    // The stub core answers n cycles after it sees sig_start (never, if n is huge).
    task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input int n,
                           input logic [9:0] r, input logic m, input bit spur,
                           output int lat, output logic [15:0] res, output bit err,
                           output int nstart, output bit sign_ok, output bit in_ok,
                           output bit rdy0);
        int ss_cyc;
        logic [31:0] rnd;
        @(negedge clk);
        rdy0 = bus.ready;
        bus.start = 1'b1; bus.op_a = a; bus.op_b = b;
        ss_cyc = -1; nstart = 0; lat = -1; sign_ok = 1'b1; in_ok = 1'b1;
        res = 16'hxxxx; err = 1'b0;
        for (int cyc = 2; cyc <= 80 && lat < 0; cyc++) begin
            @(negedge clk);
            rnd = $urandom;
            bus.start = spur ? rnd[20] : 1'b0;
            bus.op_a  = rnd[15:0];
            bus.op_b  = rnd[31:16];
            if (bus.sig_start) begin
                nstart++;
                ss_cyc = cyc;
                if (bus.sig_hidden_a !== 1'b1 || bus.sig_hidden_b !== 1'b1 ||
                    bus.sig_input_a !== a[9:0] || bus.sig_input_b !== b[9:0]) in_ok = 1'b0;
            end
            if (!bus.ready && bus.sig_sign !== (a[15] ^ b[15])) sign_ok = 1'b0;
            if (ss_cyc > 0 && cyc == ss_cyc + n) begin
                bus.sig_valid = 1'b1; bus.sig_result = r; bus.sig_msb = m;
            end else begin
                // Stray strobe during CAPTURE must be ignored.
                bus.sig_valid  = spur && cyc == 2;
                bus.sig_result = rnd[9:0];
                bus.sig_msb    = rnd[10];
            end
            if (bus.result_valid) begin
                lat = cyc; res = bus.result; err = bus.timeout_err;
                bus.start = 1'b0; bus.sig_valid = 1'b0;
            end
        end
        bus.start = 1'b0;
        bus.sig_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0; bus.op_a = '0; bus.op_b = '0;
        bus.sig_valid = 1'b0; bus.sig_result = '0; bus.sig_msb = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (bus.result !== 16'h0 || bus.result_valid !== 1'b0 || bus.sig_start !== 1'b0 ||
            bus.timeout_err !== 1'b0 || bus.sig_input_a !== 10'h0 || bus.ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_state: result=%h rv=%b ss=%b te=%b ia=%h rdy=%b want 0000 0 0 0 000 1",
                     bus.result, bus.result_valid, bus.sig_start, bus.timeout_err,
                     bus.sig_input_a, bus.ready);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [15:0] da[6]   = '{16'h3C00, 16'hC000, 16'h7BFF, 16'h0400, 16'h7C00, 16'h7C00};
        logic [15:0] db[6]   = '{16'h3C00, 16'h4200, 16'h7BFF, 16'h0400, 16'h0000, 16'hC000};
        logic [9:0]  dr[6]   = '{10'h000, 10'h200, 10'h3FF, 10'h000, 10'h000, 10'h000};
        logic        dm[6]   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [15:0] dexp[6] = '{16'h3C00, 16'hC600, 16'h7C00, 16'h0000, 16'h7E00, 16'hFC00};
        int          dlat[6] = '{16, 16, 16, 16, 3, 3};
        int lat, ns;
        logic [15:0] res;
        bit err, sok, iok, rdy;
        for (int i = 0; i < 6; i++) begin
            run_txn(da[i], db[i], 13, dr[i], dm[i], 1'b0, lat, res, err, ns, sok, iok, rdy);
            total++;
            if (res !== dexp[i]) begin
                bad++;
                $display("FAIL directed_result[%0d]: got %h want %h", i, res, dexp[i]);
            end
            total++;
            if (lat !== dlat[i] || err !== 1'b0) begin
                bad++;
                $display("FAIL directed_latency[%0d]: got lat=%0d err=%b want lat=%0d err=0",
                         i, lat, err, dlat[i]);
            end
            total++;
            if (ns !== ((dlat[i] == 3) ? 0 : 1) || !sok || !iok) begin
                bad++;
                $display("FAIL directed_core_if[%0d]: sig_start pulses=%0d sign_ok=%b in_ok=%b",
                         i, ns, sok, iok);
            end
        end
    endtask

    task automatic test_timeout();
        int ns_tab[3] = '{TIMEOUT + 1, TIMEOUT + 2, 1000};
        int lat, ns;
        logic [15:0] res, want;
        bit err, sok, iok, rdy, want_err;
        for (int i = 0; i < 3; i++) begin
            run_txn(16'h4000, 16'h4000, ns_tab[i], 10'h155, 1'b0, 1'b0, lat, res, err, ns, sok, iok, rdy);
            want_err = (i != 0);
            want     = want_err ? 16'h7E00 : 16'h4555;
            total++;
            if (res !== want || err !== want_err || lat !== TIMEOUT + 4) begin
                bad++;
                $display("FAIL timeout[%0d]: got res=%h err=%b lat=%0d want res=%h err=%b lat=%0d",
                         i, res, err, lat, want, want_err, TIMEOUT + 4);
            end
        end
        repeat (4) @(negedge clk);
        total++;
        if (bus.result !== 16'h7E00 || bus.timeout_err !== 1'b0 || bus.result_valid !== 1'b0) begin
            bad++;
            $display("FAIL result_hold: got res=%h te=%b rv=%b want 7e00 0 0",
                     bus.result, bus.timeout_err, bus.result_valid);
        end
    endtask

    task automatic test_random();
        int lat, ns, n, want_lat;
        logic [15:0] a, b, res, want;
        logic [31:0] rnd;
        bit err, sok, iok, rdy, sp, want_err;
        for (int i = 0; i < 40; i++) begin
            a = rand_op(); b = rand_op();
            n = $urandom_range(1, TIMEOUT + 4);
            rnd = $urandom;
            want = ref_mul(a, b, rnd[9:0], rnd[10], sp);
            run_txn(a, b, n, rnd[9:0], rnd[10], rnd[11], lat, res, err, ns, sok, iok, rdy);
            want_err = !sp && (n > TIMEOUT + 1);
            if (want_err) want = 16'h7E00;
            want_lat = sp ? 3 : (want_err ? TIMEOUT + 4 : n + 3);
            total++;
            if (res !== want || err !== want_err) begin
                bad++;
                $display("FAIL random_result[%0d]: a=%h b=%h n=%0d got %h err=%b want %h err=%b",
                         i, a, b, n, res, err, want, want_err);
            end
            total++;
            if (lat !== want_lat || ns !== (sp ? 0 : 1) || !sok || !iok) begin
                bad++;
                $display("FAIL random_timing[%0d]: a=%h b=%h got lat=%0d starts=%0d sok=%b iok=%b want lat=%0d starts=%0d",
                         i, a, b, lat, ns, sok, iok, want_lat, sp ? 0 : 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat, ns;
        logic [15:0] res;
        bit err, sok, iok, rdy;
        run_txn(16'h3C00, 16'hC000, 5, 10'h000, 1'b0, 1'b0, lat, res, err, ns, sok, iok, rdy);
        total++;
        if (res !== 16'hC000 || lat !== 8) begin
            bad++;
            $display("FAIL b2b_first: got %h lat=%0d want c000 lat=8", res, lat);
        end
        run_txn(16'h7E01, 16'h3C00, 5, 10'h000, 1'b0, 1'b0, lat, res, err, ns, sok, iok, rdy);
        total++;
        if (rdy !== 1'b1 || res !== 16'h7E00 || lat !== 3 || ns !== 0) begin
            bad++;
            $display("FAIL b2b_second: ready=%b got %h lat=%0d starts=%0d want 1 7e00 3 0",
                     rdy, res, lat, ns);
        end
    endtask

    task automatic test_midop_reset();
        int lat, ns, seen;
        logic [15:0] res;
        bit err, sok, iok, rdy;
        @(negedge clk);
        bus.start = 1'b1; bus.op_a = 16'hC000; bus.op_b = 16'h4000;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (bus.result !== 16'h0 || bus.result_valid !== 1'b0 || bus.sig_start !== 1'b0 ||
            bus.timeout_err !== 1'b0 || bus.sig_sign !== 1'b0 || bus.sig_input_a !== 10'h0 ||
            bus.ready !== 1'b1) begin
            bad++;
            $display("FAIL midop_reset_state: result=%h rv=%b ss=%b te=%b sign=%b rdy=%b",
                     bus.result, bus.result_valid, bus.sig_start, bus.timeout_err,
                     bus.sig_sign, bus.ready);
        end
        reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            bus.sig_valid = (c == 9);
            @(negedge clk);
            if (bus.result_valid) seen++;
        end
        bus.sig_valid = 1'b0;
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL midop_no_result: result_valid pulses=%0d want 0", seen);
        end
        run_txn(16'h4000, 16'h4000, 13, 10'h000, 1'b0, 1'b0, lat, res, err, ns, sok, iok, rdy);
        total++;
        if (res !== 16'h4400 || lat !== 16 || err !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_txn: got %h lat=%0d err=%b want 4400 16 0", res, lat, err);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_timeout();
        test_random();
        test_back_to_back();
        test_midop_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
